// File: rtl/pe_dbuf_bank_if.sv
// Loader / PE-side bus of the ping-pong data buffer.
// The master is the loader plus the PE read control; the slave is the buffer.
interface pe_dbuf_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  // Write side (loader)
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              wr_ready;

  // Read side (AGU / PE)
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              rd_done;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              rd_last_o;

  // Sticky protocol error
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done,
    output rd_en, rd_addr, rd_last, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_vld, rd_last_o, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done,
    input  rd_en, rd_addr, rd_last, rd_done,
    output wr_ready, rd_ready, rd_data, rd_vld, rd_last_o, err
  );
endinterface

// File: rtl/pe_dbuf_bank.sv
// Ping-pong data buffer between the loader and the PE.
// Two banks: the loader fills bank wr_sel while the PE reads bank rd_sel.
// Ownership moves with wr_done / rd_done. Read data appears two edges
// after the issuing edge, with the rd_last tag travelling alongside.
module pe_dbuf_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2   // set by the two-register read path below; keep at 2
) (
  input  logic          clk,
  input  logic          rst,
  pe_dbuf_bank_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Bank ownership / occupancy
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       err_q;

  // Handshake decode
  logic wr_ready;
  logic rd_ready;
  logic wr_ok;
  logic rd_ok;
  logic wr_done_ok;
  logic rd_done_ok;
  logic proto_err;

  // Both banks share one array; the bank select is the MSB of the physical address.
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [DATA_W-1:0] rd_q;       // RAM read register, captured at issue
  logic [DATA_W-1:0] rd_q2;      // RAM output register
  logic [DATA_W-1:0] rd_data_q;  // output register, holds between reads

  // Valid / last tags, one bit per pipeline stage after the issuing edge
  logic [RD_LAT:0] v_pipe;
  logic [RD_LAT:0] l_pipe;

  assign wr_ready   = !full[wr_sel];
  assign rd_ready   = full[rd_sel];
  assign wr_ok      = bus.wr_en   && wr_ready;
  assign rd_ok      = bus.rd_en   && rd_ready;
  assign wr_done_ok = bus.wr_done && wr_ready;
  assign rd_done_ok = bus.rd_done && rd_ready;

  // Any strobe toward a side that does not currently own a usable bank is a protocol error.
  // On a same-bank wr_done/rd_done collision the bank is either full or not, so exactly one
  // of the two is legal and the other lands here.
  assign proto_err = ((bus.wr_en || bus.wr_done) && !wr_ready) ||
                     ((bus.rd_en || bus.rd_done) && !rd_ready);

  // Occupancy update: wr_done fills the write bank, rd_done releases the read bank.
  always_comb begin
    // NOTE: default first so every path assigns full_nxt; a missing branch would infer a latch.
    full_nxt = full;
    if (wr_done_ok) full_nxt[wr_sel] = 1'b1;
    if (rd_done_ok) full_nxt[rd_sel] = 1'b0;
  end

  // Bank ownership and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full   <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_done_ok) wr_sel <= !wr_sel;
      if (rd_done_ok) rd_sel <= !rd_sel;
      err_q <= err_q || proto_err;
    end
  end

  // RAM: write port, registered read (bank sampled at issue) and RAM output register.
  always_ff @(posedge clk) begin
    // NOTE: the array and its read registers carry no reset so the tools can map them to block RAM.
    if (wr_ok)     mem[{wr_sel, bus.wr_addr}] <= bus.wr_data;
    if (rd_ok)     rd_q  <= mem[{rd_sel, bus.rd_addr}];
    if (v_pipe[0]) rd_q2 <= rd_q;
  end

  // Tag pipeline and output register; reset flushes reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe    <= '0;
      l_pipe    <= '0;
      rd_data_q <= '0;
    end else begin
      v_pipe <= {v_pipe[RD_LAT-1:0], rd_ok};
      l_pipe <= {l_pipe[RD_LAT-1:0], rd_ok && bus.rd_last};
      if (v_pipe[RD_LAT-1]) rd_data_q <= rd_q2;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.rd_ready  = rd_ready;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_vld    = v_pipe[RD_LAT];
  assign bus.rd_last_o = l_pipe[RD_LAT];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pe_dbuf_bank.sv
// Self-checking bench for pe_dbuf_bank: directed scenarios followed by
// random traffic, all compared every cycle against a bank/queue model.
module tb_pe_dbuf_bank;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_dbuf_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pe_dbuf_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  // Reference model: plain bank arrays, ownership flags, and a queue of
  // expected read returns stamped with the edge at which they must appear.
  typedef struct {
    longint        due;
    logic [DW-1:0] d;
    bit            known;
    bit            last;
  } rd_t;

  rd_t           m_q[$];
  logic [DW-1:0] m_mem   [2][NW];
  bit            m_known [2][NW];
  bit   [1:0]    m_full;
  bit            m_wsel;
  bit            m_rsel;
  bit            m_err;
  logic [DW-1:0] m_hold;
  bit            m_hold_known;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_full       = 2'b00;
    m_wsel       = 1'b0;
    m_rsel       = 1'b0;
    m_err        = 1'b0;
    m_hold       = '0;
    m_hold_known = 1'b1;
    m_q.delete();
    // Buffer contents are not guaranteed across reset.
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NW; a++)
        m_known[b][a] = 1'b0;
  endtask

  task automatic clr();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_last = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  // Apply the current inputs to the model, clock one edge, compare all outputs.
  task automatic tick();
    bit  w_ok;
    bit  r_ok;
    rd_t e;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      w_ok = !m_full[m_wsel];
      r_ok = m_full[m_rsel];
      if (bus.rd_en) begin
        if (r_ok) begin
          e.due   = cyc + 2;
          e.d     = m_mem[m_rsel][bus.rd_addr];
          e.known = m_known[m_rsel][bus.rd_addr];
          e.last  = bus.rd_last;
          m_q.push_back(e);
        end else m_err = 1'b1;
      end
      if (bus.wr_en) begin
        if (w_ok) begin
          m_mem[m_wsel][bus.wr_addr]   = bus.wr_data;
          m_known[m_wsel][bus.wr_addr] = 1'b1;
        end else m_err = 1'b1;
      end
      if (bus.wr_done) begin
        if (w_ok) begin
          m_full[m_wsel] = 1'b1;
          m_wsel         = !m_wsel;
        end else m_err = 1'b1;
      end
      if (bus.rd_done) begin
        if (r_ok) begin
          m_full[m_rsel] = 1'b0;
          m_rsel         = !m_rsel;
        end else m_err = 1'b1;
      end
    end

    @(posedge clk);
    #1;

    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      e = m_q.pop_front();
      check("rd_vld", 64'(bus.rd_vld), 64'd1);
      check("rd_last_o", 64'(bus.rd_last_o), 64'(e.last));
      if (e.known) check("rd_data", bus.rd_data, e.d);
      m_hold       = e.d;
      m_hold_known = e.known;
    end else begin
      check("rd_vld_idle", 64'(bus.rd_vld), 64'd0);
      if (m_hold_known) check("rd_data_hold", bus.rd_data, m_hold);
    end
    check("wr_ready", 64'(bus.wr_ready), 64'(!m_full[m_wsel]));
    check("rd_ready", 64'(bus.rd_ready), 64'(m_full[m_rsel]));
    check("err", 64'(bus.err), 64'(m_err));
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    clr();
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tick();
  endtask

  task automatic rd(input int a, input bit last);
    clr();
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    bus.rd_last = last;
    tick();
  endtask

  task automatic dones(input bit wdn, input bit rdn);
    clr();
    bus.wr_done = wdn;
    bus.rd_done = rdn;
    tick();
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr();
    model_reset();

    // Reset, then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(10);
    check("rst_rd_last_o", 64'(bus.rd_last_o), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);

    // Fill bank0 with A0..A3, hand over, read back in reverse with last on addr 0
    for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i));
    dones(1'b1, 1'b0);
    check("fill0_rd_ready", 64'(bus.rd_ready), 64'd1);
    check("fill0_wr_ready", 64'(bus.wr_ready), 64'd1);
    rd(3, 1'b0);
    rd(2, 1'b0);
    rd(1, 1'b0);
    rd(0, 1'b1);
    idle(2);
    check("a0_vld", 64'(bus.rd_vld), 64'd1);
    check("a0_data", bus.rd_data, 64'hA0);
    check("a0_last", 64'(bus.rd_last_o), 64'd1);

    // Ping-pong: fill bank1 while reading bank0, then swap under an in-flight read
    for (int i = 0; i < 4; i++) begin
      clr();
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = 64'hB0 + 64'(i);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(i);
      tick();
    end
    dones(1'b1, 1'b0);
    clr();
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(1);
    bus.rd_done = 1'b1;
    tick();
    rd(0, 1'b0);
    idle(1);
    check("swap_old_bank", bus.rd_data, 64'hA1);
    idle(1);
    check("swap_new_bank", bus.rd_data, 64'hB0);

    // Both banks full: write is dropped and flags err, bank1 is untouched
    for (int i = 0; i < 4; i++) wr(i, 64'hC0 + 64'(i));
    dones(1'b1, 1'b0);
    check("both_full_wr_ready", 64'(bus.wr_ready), 64'd0);
    wr(0, 64'hDEAD);
    check("drop_err", 64'(bus.err), 64'd1);
    rd(0, 1'b0);
    idle(2);
    check("bank1_kept", bus.rd_data, 64'hB0);

    // Simultaneous rd_done (bank0) and wr_done (bank1)
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, 64'hD0 + 64'(i));
    dones(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) wr(i, 64'hE0 + 64'(i));
    dones(1'b1, 1'b1);
    check("sim_diff_rd_ready", 64'(bus.rd_ready), 64'd1);
    check("sim_diff_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("sim_diff_err", 64'(bus.err), 64'd0);
    rd(2, 1'b1);
    idle(2);
    check("sim_diff_data", bus.rd_data, 64'hE2);

    // Simultaneous wr_done and rd_done on the same full bank: rd_done wins
    for (int i = 0; i < 4; i++) wr(i, 64'hF0 + 64'(i));
    dones(1'b1, 1'b0);
    dones(1'b1, 1'b1);
    check("same_bank_err", 64'(bus.err), 64'd1);
    check("same_bank_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("same_bank_rd_ready", 64'(bus.rd_ready), 64'd1);
    rd(1, 1'b0);
    idle(2);
    check("same_bank_data", bus.rd_data, 64'hF1);

    // Reset with two reads in flight
    rd(0, 1'b0);
    rd(1, 1'b0);
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_rd_vld", 64'(bus.rd_vld), 64'd0);
    check("mid_rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("mid_rst_err", 64'(bus.err), 64'd0);

    // Random traffic over a small address window so reads hit written words
    for (int n = 0; n < 3000; n++) begin
      clr();
      rst         = ($urandom_range(0, 299) == 0);
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = AW'($urandom_range(0, 15));
      bus.wr_data = {$urandom, $urandom};
      bus.wr_done = ($urandom_range(0, 11) == 0);
      bus.rd_en   = 1'($urandom_range(0, 1));
      bus.rd_addr = AW'($urandom_range(0, 15));
      bus.rd_last = 1'($urandom_range(0, 1));
      bus.rd_done = ($urandom_range(0, 11) == 0);
      tick();
    end
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
